// File: rtl/ascon_perm_core_pkg.sv
// Shared types, constants and helpers for the iterative Ascon permutation engine.
package ascon_perm_core_pkg;

  localparam int STATE_WIDTH  = 320;
  localparam int MAX_ROUND_NO = 16;

  localparam logic [63:0] ASCON_AEAD128_IV = 64'h00001000808c0001;

  typedef logic [63:0] ascon_word_t;
  typedef ascon_word_t [4:0] ascon_state_t;

  typedef enum logic [1:0] {
    PermIdle = 2'd0,
    PermRun  = 2'd1,
    PermDone = 2'd2
  } perm_state_e;

  // Linear-layer rotation amounts, indexed by word number (0 = x0).
  localparam int unsigned ROT_A [5] = '{32'd19, 32'd61, 32'd1, 32'd10, 32'd7};
  localparam int unsigned ROT_B [5] = '{32'd28, 32'd39, 32'd6, 32'd17, 32'd41};

  function automatic ascon_word_t ascon_ror(input ascon_word_t x, input int unsigned amt);
    return (x >> amt) | (x << (32'd64 - amt));
  endfunction

  // Round i of an n-round call reads the tail of the table, so every n ends on 8'h4b.
  function automatic logic [7:0] ascon_round_const(input logic [4:0] n, input logic [4:0] i);
    logic [4:0] idx;
    logic [7:0] rc;
    idx = 5'(MAX_ROUND_NO) - n + i;
    case (idx)
      5'd0:    rc = 8'h3c;
      5'd1:    rc = 8'h2d;
      5'd2:    rc = 8'h1e;
      5'd3:    rc = 8'h0f;
      5'd4:    rc = 8'hf0;
      5'd5:    rc = 8'he1;
      5'd6:    rc = 8'hd2;
      5'd7:    rc = 8'hc3;
      5'd8:    rc = 8'hb4;
      5'd9:    rc = 8'ha5;
      5'd10:   rc = 8'h96;
      5'd11:   rc = 8'h87;
      5'd12:   rc = 8'h78;
      5'd13:   rc = 8'h69;
      5'd14:   rc = 8'h5a;
      5'd15:   rc = 8'h4b;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, bitsliced S-box, linear diffusion.
module ascon_round
  import ascon_perm_core_pkg::*;
(
  input  logic [STATE_WIDTH-1:0] state,
  input  logic [7:0]             round_const,
  output logic [STATE_WIDTH-1:0] next_state
);

  ascon_word_t x [5];
  ascon_word_t t [5];

  // Round datapath; x[0] is the most significant word of the state.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      x[k] = state[319 - 64*k -: 64];
    end
    x[2] = x[2] ^ {56'h0, round_const};

    x[0] = x[0] ^ x[4];
    x[4] = x[4] ^ x[3];
    x[2] = x[2] ^ x[1];
    t[0] = ~x[0] & x[1];
    t[1] = ~x[1] & x[2];
    t[2] = ~x[2] & x[3];
    t[3] = ~x[3] & x[4];
    t[4] = ~x[4] & x[0];
    x[0] = x[0] ^ t[1];
    x[1] = x[1] ^ t[2];
    x[2] = x[2] ^ t[3];
    x[3] = x[3] ^ t[4];
    x[4] = x[4] ^ t[0];
    x[1] = x[1] ^ x[0];
    x[0] = x[0] ^ x[4];
    x[3] = x[3] ^ x[2];
    x[2] = ~x[2];

    next_state = '0;
    for (int k = 0; k < 5; k++) begin
      next_state[319 - 64*k -: 64] = x[k] ^ ascon_ror(x[k], ROT_A[k]) ^ ascon_ror(x[k], ROT_B[k]);
    end
  end

endmodule

// File: rtl/ascon_perm_core.sv
// Iterative Ascon p^n engine, UNROLL rounds per clock, valid/ready on both sides.
module ascon_perm_core
  import ascon_perm_core_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [STATE_WIDTH-1:0] in_state_i,
  input  logic [4:0]             in_rounds_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [STATE_WIDTH-1:0] out_state_o,
  output logic                   out_err_o
);

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("ascon_perm_core: UNROLL must be 1, 2 or 4");
  end

  localparam logic [4:0] STEP  = 5'(UNROLL);
  localparam logic [4:0] MAX_N = 5'(MAX_ROUND_NO);

  perm_state_e  fsm_r;
  logic [4:0]   cnt_r;
  logic [4:0]   rounds_r;
  logic [4:0]   cnt_next_s;
  ascon_state_t data_r;
  logic         err_r;
  logic         accept_s;
  logic         legal_s;
  ascon_state_t chain_s [UNROLL+1];

  assign legal_s    = (in_rounds_i != 5'd0) && (in_rounds_i <= MAX_N) &&
                      ((in_rounds_i & (STEP - 5'd1)) == 5'd0);
  assign accept_s   = in_valid_i & in_ready_o;
  assign cnt_next_s = cnt_r + STEP;

  assign chain_s[0] = data_r;
  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [7:0] rc_s;
    assign rc_s = ascon_round_const(rounds_r, cnt_r + 5'(u));
    ascon_round u_round (
      .state       (chain_s[u]),
      .round_const (rc_s),
      .next_state  (chain_s[u+1])
    );
  end

  // Ready while idle, or while a finished result is being consumed this cycle.
  always_comb begin
    in_ready_o = 1'b0;
    case (fsm_r)
      PermIdle: in_ready_o = 1'b1;
      PermDone: in_ready_o = out_ready_i;
      default:  in_ready_o = 1'b0;
    endcase
  end

  assign out_valid_o = (fsm_r == PermDone);
  assign out_state_o = data_r;
  assign out_err_o   = err_r;

  // Control FSM and state register; reset discards any in-flight request.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_r    <= PermIdle;
      cnt_r    <= 5'd0;
      rounds_r <= 5'd0;
      data_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      case (fsm_r)
        PermRun: begin
          data_r <= chain_s[UNROLL];
          cnt_r  <= cnt_next_s;
          if (cnt_next_s == rounds_r) begin
            fsm_r <= PermDone;
          end
        end
        PermIdle, PermDone: begin
          if (accept_s) begin
            data_r   <= in_state_i;
            rounds_r <= in_rounds_i;
            cnt_r    <= 5'd0;
            err_r    <= ~legal_s;
            fsm_r    <= legal_s ? PermRun : PermDone;
          end else if (fsm_r == PermDone && out_ready_i) begin
            fsm_r <= PermIdle;
          end
        end
        default: fsm_r <= PermIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_perm_core.sv
// Scoreboard bench for ascon_perm_core: one UNROLL=1 and one UNROLL=4 instance.
module tb_ascon_perm_core;

  localparam logic [63:0] IV = 64'h00001000808c0001;
  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC_TAB [16] = '{
    8'h3c, 8'h2d, 8'h1e, 8'h0f, 8'hf0, 8'he1, 8'hd2, 8'hc3,
    8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  typedef struct {
    logic [319:0] st;
    logic         err;
    int           lat;
    int           acc;
  } item_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [319:0] in_state  [2];
  logic [4:0]   in_rounds [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [319:0] out_state [2];
  logic         out_err   [2];

  int    cyc = 0;
  int    n_checks = 0;
  int    n_err = 0;
  item_t sb [2][$];
  bit    active [2];
  int    vstart [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ascon_perm_core #(.UNROLL(1)) u_dut_u1 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[0]), .in_ready_o(in_ready[0]),
    .in_state_i(in_state[0]), .in_rounds_i(in_rounds[0]),
    .out_valid_o(out_valid[0]), .out_ready_i(out_ready[0]),
    .out_state_o(out_state[0]), .out_err_o(out_err[0]));

  ascon_perm_core #(.UNROLL(4)) u_dut_u4 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid[1]), .in_ready_o(in_ready[1]),
    .in_state_i(in_state[1]), .in_rounds_i(in_rounds[1]),
    .out_valid_o(out_valid[1]), .out_ready_i(out_ready[1]),
    .out_state_o(out_state[1]), .out_err_o(out_err[1]));

  function automatic logic [63:0] rotr(input logic [63:0] v, input int s);
    return (v >> s) | (v << (64 - s));
  endfunction

  // Reference permutation: S-box by table lookup, one column at a time.
  function automatic logic [319:0] model_perm(input logic [319:0] st, input int n);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    logic [4:0]  sv;
    for (int k = 0; k < 5; k++) x[k] = st[319-64*k -: 64];
    for (int r = 0; r < n; r++) begin
      x[2] = x[2] ^ {56'h0, RC_TAB[16-n+r]};
      for (int j = 0; j < 64; j++) begin
        col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
        sv  = SBOX[col];
        for (int k = 0; k < 5; k++) y[k][j] = sv[4-k];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic void check(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: latch the first valid cycle, compare on each handshake.
  always @(negedge clk) begin
    item_t it;
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        active[g] = 1'b0;
      end else if (out_valid[g]) begin
        if (!active[g]) begin
          active[g] = 1'b1;
          vstart[g] = cyc;
        end
        if (out_ready[g]) begin
          if (sb[g].size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL unexpected_result dut%0d: got state %h err %b", g, out_state[g], out_err[g]);
          end else begin
            it = sb[g].pop_front();
            check($sformatf("state dut%0d acc%0d", g, it.acc), out_state[g], it.st);
            check($sformatf("err dut%0d acc%0d", g, it.acc), 320'(out_err[g]), 320'(it.err));
            check_int($sformatf("latency dut%0d acc%0d", g, it.acc), vstart[g] - it.acc, it.lat);
          end
          active[g] = 1'b0;
        end
      end
    end
  end

  task automatic send(input int g, input logic [319:0] st, input logic [4:0] n,
                      input logic [319:0] exp_st, input logic exp_err, input int exp_lat,
                      output int acc);
    bit    got;
    item_t it;
    got = 1'b0;
    acc = -1;
    in_valid[g]  = 1'b1;
    in_state[g]  = st;
    in_rounds[g] = n;
    for (int b = 0; b < 64 && !got; b++) begin
      @(negedge clk);
      if (in_ready[g]) begin
        got    = 1'b1;
        acc    = cyc;
        it.st  = exp_st;
        it.err = exp_err;
        it.lat = exp_lat;
        it.acc = acc;
        sb[g].push_back(it);
      end
      @(posedge clk); #1;
    end
    in_valid[g] = 1'b0;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL accept_timeout dut%0d: got no accept expected accept within 64 cycles", g);
    end
  endtask

  task automatic drain(input int g);
    bit empty;
    empty = 1'b0;
    for (int b = 0; b < 100 && !empty; b++) begin
      if (sb[g].size() == 0) empty = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!empty) begin
      n_checks++;
      n_err++;
      $display("FAIL result_timeout dut%0d: got %0d pending expected 0", g, sb[g].size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [319:0] iv_st, rnd, rnd2, ones, exp8;
    int acc, issue;
    iv_st = {IV, 256'h0};
    rnd   = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
             64'hdeadbeefcafef00d, 64'h1122334455667788};
    rnd2  = {64'ha5a5a5a55a5a5a5a, 64'h0000000100000002, 64'h8000000000000001,
             64'h13579bdf2468ace0, 64'hffff0000ffff0000};
    ones  = '1;

    rst = 1'b1;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0; in_state[g] = '0; in_rounds[g] = 5'd0; out_ready[g] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("reset in_ready dut%0d", g), 320'(in_ready[g]), 320'd1);
      check($sformatf("reset out_valid dut%0d", g), 320'(out_valid[g]), 320'd0);
      check($sformatf("reset out_err dut%0d", g), 320'(out_err[g]), 320'd0);
      check($sformatf("reset out_state dut%0d", g), out_state[g], 320'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // p^12 of the AEAD128 initial state, one round per clock
    send(0, iv_st, 5'd12, model_perm(iv_st, 12), 1'b0, 13, acc);
    drain(0);
    // p^8 with four rounds per clock
    send(1, rnd, 5'd8, model_perm(rnd, 8), 1'b0, 3, acc);
    drain(1);
    // illegal counts back to back, then a legal one clears the error flag
    send(1, rnd,  5'd6,  rnd,  1'b1, 1, acc);
    send(1, rnd2, 5'd0,  rnd2, 1'b1, 1, acc);
    send(1, ~rnd, 5'd17, ~rnd, 1'b1, 1, acc);
    send(1, rnd2, 5'd4,  model_perm(rnd2, 4), 1'b0, 2, acc);
    drain(1);
    // single round on all-ones
    send(0, ones, 5'd1, model_perm(ones, 1), 1'b0, 2, acc);
    send(0, rnd,  5'd16, model_perm(rnd, 16), 1'b0, 17, acc);
    drain(0);

    // output stall for 5 cycles, then back-to-back accept
    exp8 = model_perm(rnd2, 8);
    out_ready[1] = 1'b0;
    send(1, rnd2, 5'd8, exp8, 1'b0, 3, acc);
    for (int b = 0; b < 20 && !out_valid[1]; b++) @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      check($sformatf("stall state c%0d", s), out_state[1], exp8);
      check($sformatf("stall in_ready c%0d", s), 320'(in_ready[1]), 320'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    issue = cyc;
    send(1, rnd, 5'd4, model_perm(rnd, 4), 1'b0, 2, acc);
    check_int("back_to_back accept cycle", acc, issue);
    drain(1);

    // reset in cycle 5 of an n=12 run; the idle instance sees a request during reset
    in_valid[0] = 1'b1; in_state[0] = iv_st; in_rounds[0] = 5'd12;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("run in_ready", 320'(in_ready[0]), 320'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    in_valid[1] = 1'b1; in_state[1] = rnd; in_rounds[1] = 5'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid[1] = 1'b0;
    @(negedge clk);
    check("post_reset in_ready", 320'(in_ready[0]), 320'd1);
    check("post_reset out_valid", 320'(out_valid[0]), 320'd0);
    check("post_reset out_state", out_state[0], 320'd0);
    check("post_reset out_err", 320'(out_err[0]), 320'd0);
    check("reset_wins out_state", out_state[1], 320'd0);
    repeat (4) @(posedge clk);
    #1;
    send(0, iv_st, 5'd12, model_perm(iv_st, 12), 1'b0, 13, acc);
    drain(0);
    drain(1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
